guess_entry: RTL

Player-side guess producer for the 1A2B game. Collects decimal digits one at a time from the keypad front end, supports backspace, optionally rejects repeated digits, and presents a completed 4-digit guess on `ans0`..`ans3` to the datapath via a valid/ready handshake. Also counts the guesses submitted in the current round.

---
 rtl/guess_entry.sv | 123 ++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// Player-side 1A2B guess entry: collects four keypad digits with backspace, then offers them via valid/ready.
// Optional repeated-digit rejection is enabled by defining GUESS_ENTRY_DUP_CHECK_EN.
module guess_entry #(
    parameter int unsigned MAX_GUESS = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       del,
    input  logic       submit,
    input  logic       new_round,
    input  logic       guess_ready,
    output logic [3:0] ans0,
    output logic [3:0] ans1,
    output logic [3:0] ans2,
    output logic [3:0] ans3,
    output logic       guess_valid,
    output logic [2:0] entry_count,
    output logic       entry_error,
    output logic [3:0] guess_num
);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic [2:0]       count_q, count_d;
    logic             err_q, err_d;
    logic [3:0]       gnum_q, gnum_d;
    logic             dup_hit;
    logic             digit_ok;
    logic             full;

`ifdef GUESS_ENTRY_DUP_CHECK_EN
    // A slot only participates in the duplicate search once it has been filled.
    logic [3:0] slot_match;
    for (genvar gi = 0; gi < 4; gi++) begin : g_dup
        assign slot_match[gi] = (3'(gi) < count_q) && (slot_q[gi] == digit);
    end
    assign dup_hit = |slot_match;
`else
    assign dup_hit = 1'b0;
`endif

    assign full     = (count_q == 3'd4);
    assign digit_ok = (digit <= 4'd9) && !full && !dup_hit;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        count_d = count_q;
        err_d   = 1'b0;
        gnum_d  = gnum_q;

        if (new_round) begin
            state_d = COLLECT;
            slot_d  = '0;
            count_d = '0;
            gnum_d  = '0;
        end else if (state_q == SEND) begin
            // Guess is frozen; any edit strobe is refused while the transfer is pending.
            err_d = digit_valid | del | submit;
            if (guess_ready) begin
                state_d = COLLECT;
                slot_d  = '0;
                count_d = '0;
                if (gnum_q < 4'(MAX_GUESS)) begin
                    gnum_d = gnum_q + 4'd1;
                end
            end
        end else if (del) begin
            if (count_q != 3'd0) begin
                slot_d[2'(count_q - 3'd1)] = '0;
                count_d                    = count_q - 3'd1;
            end else begin
                err_d = 1'b1;
            end
        end else if (digit_valid) begin
            if (digit_ok) begin
                slot_d[count_q[1:0]] = digit;
                count_d              = count_q + 3'd1;
            end else begin
                err_d = 1'b1;
            end
        end else if (submit) begin
            if (full) begin
                state_d = SEND;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COLLECT;
            slot_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            gnum_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            err_q   <= err_d;
            gnum_q  <= gnum_d;
        end
    end

    assign ans0        = slot_q[0];
    assign ans1        = slot_q[1];
    assign ans2        = slot_q[2];
    assign ans3        = slot_q[3];
    assign guess_valid = (state_q == SEND);
    assign entry_count = count_q;
    assign entry_error = err_q;
    assign guess_num   = gnum_q;

endmodule
